// File: rtl/seg7_capture_if.sv
// Bundle for the scanned 7-segment display tap: raw segment/anode inputs
// plus the decoded digit and event outputs.
interface seg7_capture_if;
   logic [6:0]  seg_n;
   logic [3:0]  an_n;
   logic [15:0] bcd_out;
   logic [3:0]  digit_valid;
   logic        upd;
   logic        err;
   logic [7:0]  err_count;
   logic        frame_done;

   modport master (
      output seg_n, an_n,
      input  bcd_out, digit_valid, upd, err, err_count, frame_done
   );

   modport slave (
      input  seg_n, an_n,
      output bcd_out, digit_valid, upd, err, err_count, frame_done
   );
endinterface

// File: rtl/seg7_capture.sv
// Recovers the four BCD digits shown on a multiplexed common-anode display by
// watching its segment/anode lines and accepting only patterns that stay stable.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | no single digit is being scanned; counter held at 0
//   TRACK | one digit enabled, counting consecutive identical samples
//   HOLD  | current sample already accepted; waiting for it to change
module seg7_capture #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input logic          clk,
   input logic          rst,
   seg7_capture_if.slave bus
);

   localparam logic [7:0] CNT_LAST   = 8'(STABLE_CYCLES - 1);
   localparam logic [7:0] CNT_ACCEPT = 8'(STABLE_CYCLES);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      HOLD  = 2'd2
   } state_e;

   logic [6:0]  seg_s1, seg_s2;
   logic [3:0]  an_s1, an_s2;

   state_e      state;
   logic [7:0]  cnt;
   logic [10:0] prev;
   logic [15:0] bcd_q;
   logic [3:0]  valid_q;
   logic        upd_q;
   logic        err_q;
   logic [7:0]  err_count_q;
   logic        frame_done_q;
   logic [3:0]  seen;

   logic        scannable;
   logic [1:0]  pos;
   logic [10:0] sample;
   logic        legal;
   logic        blank;
   logic [3:0]  digit;
   logic [3:0]  seen_next;

   // Synchronisers idle at all-ones so reset looks like "display dark".
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_s1 <= '1;
         seg_s2 <= '1;
         an_s1  <= '1;
         an_s2  <= '1;
      end else begin
         seg_s1 <= bus.seg_n;
         seg_s2 <= seg_s1;
         an_s1  <= bus.an_n;
         an_s2  <= an_s1;
      end
   end

   assign sample = {an_s2, seg_s2};

   always_comb begin
      scannable = 1'b1;
      pos       = 2'd0;
      case (an_s2)
         4'b1110: pos = 2'd0;
         4'b1101: pos = 2'd1;
         4'b1011: pos = 2'd2;
         4'b0111: pos = 2'd3;
         default: scannable = 1'b0;
      endcase
   end

   always_comb begin
      legal = 1'b1;
      blank = 1'b0;
      digit = 4'd0;
      case (seg_s2)
         7'b1000000: digit = 4'd0;
         7'b1111001: digit = 4'd1;
         7'b0100100: digit = 4'd2;
         7'b0110000: digit = 4'd3;
         7'b0011001: digit = 4'd4;
         7'b0010010: digit = 4'd5;
         7'b0000010: digit = 4'd6;
         7'b1111000: digit = 4'd7;
         7'b0000000: digit = 4'd8;
         7'b0010000: digit = 4'd9;
         7'b1111111: begin
            legal = 1'b0;
            blank = 1'b1;
         end
         default: legal = 1'b0;
      endcase
   end

   assign seen_next = seen | ~an_s2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         prev         <= '1;
         bcd_q        <= '0;
         valid_q      <= '0;
         upd_q        <= 1'b0;
         err_q        <= 1'b0;
         err_count_q  <= '0;
         frame_done_q <= 1'b0;
         seen         <= '0;
      end else begin
         upd_q        <= 1'b0;
         err_q        <= 1'b0;
         frame_done_q <= 1'b0;
         if (!scannable) begin
            state <= IDLE;
            cnt   <= '0;
         end else begin
            case (state)
               IDLE: begin
                  state <= TRACK;
                  cnt   <= 8'd1;
                  prev  <= sample;
               end
               TRACK: begin
                  if (sample != prev) begin
                     prev <= sample;
                     cnt  <= 8'd1;
                  end else if (cnt == CNT_LAST) begin
                     // Accept: the counter reaches STABLE_CYCLES on this edge.
                     cnt   <= CNT_ACCEPT;
                     state <= HOLD;
                     upd_q <= 1'b1;
                     if (legal) begin
                        bcd_q[4*pos +: 4] <= digit;
                        valid_q[pos]      <= 1'b1;
                     end else if (blank) begin
                        valid_q[pos] <= 1'b0;
                     end else begin
                        err_q <= 1'b1;
                        if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
                     end
                     if (seen_next == 4'hF) begin
                        frame_done_q <= 1'b1;
                        seen         <= '0;
                     end else begin
                        seen <= seen_next;
                     end
                  end else begin
                     cnt <= cnt + 8'd1;
                  end
               end
               HOLD: begin
                  if (sample != prev) begin
                     prev  <= sample;
                     cnt   <= 8'd1;
                     state <= TRACK;
                  end
               end
               default: begin
                  state <= IDLE;
                  cnt   <= '0;
               end
            endcase
         end
      end
   end

   assign bus.bcd_out     = bcd_q;
   assign bus.digit_valid = valid_q;
   assign bus.upd         = upd_q;
   assign bus.err         = err_q;
   assign bus.err_count   = err_count_q;
   assign bus.frame_done  = frame_done_q;

endmodule
